// File: rtl/faims_pkg.sv
// Shared types and constants for the FAIMS HV switch and coil charge sequencer.
package faims_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } faims_state_e;

    localparam int unsigned FAIMS_DEADTIME   = 2;
    localparam int unsigned FAIMS_MIN_PERIOD = 4;

    // Round-robin successor of cur in the range 0..n-1.
    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/faims_coil_sched.sv
// Round-robin coil channel selector with skip-period counter, advanced once per FAIMS period.
module faims_coil_sched
    import faims_pkg::*;
#(
    parameter int unsigned N_COILS = 2,
    parameter int unsigned CH_W    = (N_COILS > 1) ? $clog2(N_COILS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            step,
    input  logic [7:0]      skip,
    output logic [CH_W-1:0] chan,
    output logic            charge
);

    logic [CH_W-1:0] chan_q, chan_d;
    logic [7:0]      skip_cnt_q, skip_cnt_d;

    // chan_q/skip_cnt_q describe the period that starts next; stepping happens
    // during the first cycle of the period that has just consumed them.
    always_comb begin
        chan_d     = chan_q;
        skip_cnt_d = skip_cnt_q;
        if (clear) begin
            chan_d     = '0;
            skip_cnt_d = '0;
        end else if (step) begin
            if (skip_cnt_q == 8'd0) begin
                chan_d     = CH_W'(rr_next(32'(chan_q), N_COILS));
                skip_cnt_d = skip;
            end else begin
                skip_cnt_d = skip_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q     <= '0;
            skip_cnt_q <= '0;
        end else begin
            chan_q     <= chan_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign chan   = chan_q;
    assign charge = (skip_cnt_q == 8'd0);

endmodule

// File: rtl/faims_multi.sv
// FAIMS high/low HV switch generator with dead time, plus round-robin multi-channel coil charging.
module faims_multi
    import faims_pkg::*;
#(
    parameter int unsigned PERIOD_W = 10,
    parameter int unsigned WORK_W   = 8,
    parameter int unsigned N_COILS  = 2,
    parameter int unsigned DEADTIME = FAIMS_DEADTIME
) (
    input  logic                CLK,
    input  logic                i_reset_n,
    input  logic                i_enable,
    input  logic [PERIOD_W-1:0] i_parFaimsPeriod,
    input  logic [PERIOD_W-1:0] i_parFaimsPulseLen,
    input  logic [WORK_W-1:0]   i_parWork,
    input  logic [7:0]          i_parSkipPulses,
    output logic                o_faimsUp,
    output logic                o_faimsDown,
    output logic [N_COILS-1:0]  o_coilU,
    output logic [N_COILS-1:0]  o_coilD,
    output logic                o_periodStrobe,
    output logic                o_paramErr
);

    localparam int unsigned CH_W  = (N_COILS > 1) ? $clog2(N_COILS) : 1;
    localparam int unsigned EXT_W = ((PERIOD_W > WORK_W) ? PERIOD_W : WORK_W) + 4;
    typedef logic [EXT_W-1:0] ext_t;
    localparam ext_t DT_X   = ext_t'(DEADTIME);
    localparam ext_t DT2_X  = ext_t'(2 * DEADTIME);
    localparam ext_t MINP_X = ext_t'(FAIMS_MIN_PERIOD);

    faims_state_e        state_q, state_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] pulse_q, pulse_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [7:0]          skip_q, skip_d;
    logic                cur_charge_q, cur_charge_d;
    logic [CH_W-1:0]     cur_chan_q, cur_chan_d;
    logic                up_q, up_d, down_q, down_d;
    logic                strobe_q, strobe_d, err_q, err_d;
    logic [N_COILS-1:0]  coil_up_q, coil_dn_q, coil_on_d;

    logic [CH_W-1:0]     sched_chan;
    logic                sched_charge, sched_clear;
    logic                run_d, wrap, load;
    ext_t                period_clamp, work_lim, work_clamp;
    ext_t                count_x, pulse_x, period_x, work_x;

    always_comb begin
        period_clamp = ext_t'(i_parFaimsPeriod);
        if (period_clamp < MINP_X) begin
            period_clamp = MINP_X;
        end
        work_lim   = (period_clamp > DT_X) ? period_clamp - DT_X : '0;
        work_clamp = ext_t'(i_parWork);
        if (work_clamp > work_lim) begin
            work_clamp = work_lim;
        end
    end

    // Outputs are computed from next-state values so each registered output
    // lines up with the registered count it describes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_enable) state_d = ST_START;
            ST_START: state_d = i_enable ? ST_RUN : ST_IDLE;
            ST_RUN:   if (!i_enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        wrap  = (state_q == ST_RUN) && (count_q == period_q - PERIOD_W'(1));
        run_d = (state_d == ST_RUN);
        load  = run_d && ((state_q == ST_START) || wrap);

        period_d     = period_q;
        pulse_d      = pulse_q;
        work_d       = work_q;
        skip_d       = skip_q;
        cur_charge_d = cur_charge_q;
        cur_chan_d   = cur_chan_q;
        if (load) begin
            period_d     = PERIOD_W'(period_clamp);
            pulse_d      = i_parFaimsPulseLen;
            work_d       = WORK_W'(work_clamp);
            skip_d       = i_parSkipPulses;
            cur_charge_d = sched_charge;
            cur_chan_d   = sched_chan;
        end

        if (!run_d || load) begin
            count_d = '0;
        end else begin
            count_d = count_q + PERIOD_W'(1);
        end

        count_x  = ext_t'(count_d);
        pulse_x  = ext_t'(pulse_d);
        period_x = ext_t'(period_d);
        work_x   = ext_t'(work_d);

        strobe_d = run_d && (count_d == '0);
        err_d    = run_d && (pulse_x + DT2_X >= period_x);
        up_d     = run_d && (count_x < pulse_x);
        down_d   = run_d && !err_d && (count_x >= pulse_x + DT_X) && (count_x + DT_X < period_x);
    end

    for (genvar gi = 0; gi < N_COILS; gi++) begin : g_coil
        assign coil_on_d[gi] = run_d && cur_charge_d && (cur_chan_d == CH_W'(gi)) && (count_x < work_x);
    end

    always_ff @(posedge CLK or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            period_q     <= '0;
            pulse_q      <= '0;
            work_q       <= '0;
            skip_q       <= '0;
            cur_charge_q <= 1'b0;
            cur_chan_q   <= '0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            strobe_q     <= 1'b0;
            err_q        <= 1'b0;
            coil_up_q    <= '0;
            coil_dn_q    <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            period_q     <= period_d;
            pulse_q      <= pulse_d;
            work_q       <= work_d;
            skip_q       <= skip_d;
            cur_charge_q <= cur_charge_d;
            cur_chan_q   <= cur_chan_d;
            up_q         <= up_d;
            down_q       <= down_d;
            strobe_q     <= strobe_d;
            err_q        <= err_d;
            coil_up_q    <= coil_on_d;
            coil_dn_q    <= coil_on_d;
        end
    end

    // A fresh enable always restarts the rotation at channel 0.
    assign sched_clear = (state_q == ST_IDLE);

    faims_coil_sched #(
        .N_COILS (N_COILS),
        .CH_W    (CH_W)
    ) u_sched (
        .clk    (CLK),
        .rst_n  (i_reset_n),
        .clear  (sched_clear),
        .step   (strobe_q),
        .skip   (skip_q),
        .chan   (sched_chan),
        .charge (sched_charge)
    );

    assign o_faimsUp      = up_q;
    assign o_faimsDown    = down_q;
    assign o_coilU        = coil_up_q;
    assign o_coilD        = coil_dn_q;
    assign o_periodStrobe = strobe_q;
    assign o_paramErr     = err_q;

endmodule

// File: doc/faims_multi.md
FAIMS_MULTI -- requirements
Module: faims_multi

Interface
REQ-001 SHALL have parameter PERIOD_W, default 10, width of the period and pulse-length counters.
REQ-002 SHALL have parameter WORK_W, default 8, width of the coil work (charge) time.
REQ-003 SHALL have parameter N_COILS, default 2, number of coil H-bridge channels (range 1..8).
REQ-004 SHALL have parameter DEADTIME, default 2, number of idle cycles between opposite HV switch states.
REQ-005 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_enable, input, 1, run request; low forces safe idle.
REQ-008 SHALL have port i_parFaimsPeriod, input, PERIOD_W, FAIMS period in cycles.
REQ-009 SHALL have port i_parFaimsPulseLen, input, PERIOD_W, high-side pulse length in cycles.
REQ-010 SHALL have port i_parWork, input, WORK_W, coil charge length in cycles.
REQ-011 SHALL have port i_parSkipPulses, input, 8, idle periods inserted after each coil charge period.
REQ-012 SHALL have port o_faimsUp, output, 1, high-side HV switch.
REQ-013 SHALL have port o_faimsDown, output, 1, low-side HV switch.
REQ-014 SHALL have port o_coilU, output, N_COILS, per-channel upper coil switch.
REQ-015 SHALL have port o_coilD, output, N_COILS, per-channel lower coil switch.
REQ-016 SHALL have port o_periodStrobe, output, 1, one-cycle pulse on the first cycle of every period.
REQ-017 SHALL have port o_paramErr, output, 1, shadowed parameters are invalid (held per period).

Function
REQ-018 SHALL implement states IDLE, START, RUN: IDLE->START when i_enable=1; START->RUN after one cycle; any state->IDLE on the cycle after i_enable=0.
REQ-019 SHALL load all four parameters into shadow registers in START and on every period wrap only; mid-period input changes have no effect.
REQ-020 SHALL clamp the shadowed period to a minimum of 4 and clamp work to (period - DEADTIME).
REQ-021 SHALL run the period counter 0..period-1 in RUN, wrapping to 0 and asserting o_periodStrobe when the count is 0.
REQ-022 SHALL drive o_faimsUp high for count < pulseLen.
REQ-023 SHALL drive o_faimsDown high for pulseLen+DEADTIME <= count < period-DEADTIME.
REQ-024 SHALL never assert o_faimsUp and o_faimsDown together, and SHALL keep at least DEADTIME low cycles between them, including across the period wrap.
REQ-025 SHALL set o_paramErr and hold o_faimsDown low for the period when pulseLen + 2*DEADTIME >= period; o_faimsUp still pulses.
REQ-026 SHALL select the charge channel round-robin, advancing by one (mod N_COILS) after each charge period.
REQ-027 SHALL, in a charge period, drive the selected channel's o_coilU and o_coilD high for count < work; all other channel bits stay low.
REQ-028 SHALL follow each charge period with skip periods in which all coil outputs stay low.
REQ-029 SHALL make every period a charge period when skip=0.
REQ-030 SHALL treat work=0 as a charge period with no coil assertion; the channel still advances.
REQ-031 SHALL assert at most one coil channel at any cycle.
REQ-032 SHALL drive all outputs from registers, so that every output is low in IDLE and START.

Reset
REQ-033 SHALL, while i_reset_n=0, asynchronously force state=IDLE, counters=0, channel=0, skip count=0, and all outputs and shadows to 0.
REQ-034 SHALL, when reset asserts mid-period, drive all switch outputs low immediately, without waiting for a clock edge.

Structure
REQ-035 SHALL place the state encoding and the DEADTIME and minimum-period constants in the shared package faims_pkg.
REQ-036 SHALL use one sub-module, faims_coil_sched, that holds the round-robin channel select and skip counter and is stepped by o_periodStrobe.

Verification
REQ-037 SHALL cover: period=250, pulse=20, work=50, skip=0, N_COILS=2 -> Up for count 0-19; Down for count 22-247; coil0 high for count 0-49 in period 1; coil1 high in period 2.
REQ-038 SHALL cover: skip=3 -> coil pulses only in periods 1, 5 and 9, with channels 0, 1, 0.
REQ-039 SHALL cover: period=20, pulse=18 -> o_paramErr=1, Down never high, Up high for 18 cycles.
REQ-040 SHALL cover: change period 250->100 at count 120 -> the current period ends at 249, and the next period is 100 cycles.
REQ-041 SHALL cover: i_reset_n=0 while Up=1 -> all outputs low before the next edge; on release with enable=1, the first strobe occurs 2 cycles later.
REQ-042 SHALL cover: work=255 with period=100 -> coil high for count 0-97.
